// File: rtl/kv_wr_addr_gen.sv
// rtl/kv_wr_addr_gen.sv - MMU write-path address generator for general, K, V and matmul sub-sample writes
// Define KV_WR_ADDR_REG_EN to register logic_addr/phy_addr1/phy_addr2 (one cycle of latency).
module kv_wr_addr_gen #(
    parameter int DIM_MAX_LOGIC_ADDRESS = 10,
    parameter int DIM_MAX_MEM           = 14,
    parameter int DIM_TIMESTEP          = 8,
    parameter int DIM_OFFSET            = 6,
    parameter int NUM_K_BANKS           = 4,
    parameter int MM_GROUP              = 4,
    parameter int KV_DEPTH              = 800,
    parameter int TS_SHIFT              = 2,
    parameter int USE_V_STRIDE          = 4,
    parameter int USE_V_GROUPS          = 4,
    localparam int KBW                  = $clog2(NUM_K_BANKS),
    localparam int MMW                  = $clog2(MM_GROUP)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic                             valid_op,
    input  logic                             v_gen_id,
    input  logic                             k_gen_id,
    input  logic                             matmul_ss_id,
    input  logic                             use_v,
    input  logic                             end_inference,
    input  logic [DIM_OFFSET-1:0]            offset_v_ext,
    input  logic [DIM_MAX_MEM-1:0]           wr_baddr1,
    input  logic [DIM_MAX_MEM-1:0]           wr_baddr2,
    output logic [DIM_MAX_LOGIC_ADDRESS-1:0] logic_addr,
    output logic [DIM_MAX_MEM-1:0]           phy_addr1,
    output logic [DIM_MAX_MEM-1:0]           phy_addr2,
    output logic [DIM_MAX_LOGIC_ADDRESS-1:0] k_ptr,
    output logic [KBW-1:0]                   k_bank_sel,
    output logic [DIM_MAX_LOGIC_ADDRESS-1:0] v_ptr,
    output logic [DIM_TIMESTEP-1:0]          timestep,
    output logic [DIM_MAX_LOGIC_ADDRESS-1:0] gen_cnt,
    output logic [MMW-1:0]                   sel_data_int,
    output logic                             offset_mm_si,
    output logic                             v_wrap,
    output logic                             err_mode
);

    localparam int LW = DIM_MAX_LOGIC_ADDRESS;
    localparam int MW = DIM_MAX_MEM;
    localparam logic [LW-1:0]  KV_LAST    = LW'(KV_DEPTH - 1);
    localparam logic [MMW-1:0] MM_LAST    = MMW'(MM_GROUP - 1);
    localparam logic [LW-1:0]  USE_V_INC  = LW'(USE_V_STRIDE);
    localparam logic [LW-1:0]  USE_V_WRAP = LW'(USE_V_STRIDE * USE_V_GROUPS);

    logic [LW-1:0]  k_bank [NUM_K_BANKS];
    logic [LW-1:0]  offset_v;
    logic [LW-1:0]  use_v_off;
    logic [LW-1:0]  v_addr;
    logic [LW-1:0]  logic_addr_c;
    logic [MW-1:0]  phy_addr1_c;
    logic [MW-1:0]  phy_addr2_c;
    logic           grp_done;
    logic           en_gen_cnt;

    assign grp_done   = wr_en && (sel_data_int == MM_LAST);
    assign en_gen_cnt = matmul_ss_id ? grp_done : wr_en;

    // Matmul sub-sample group index: restarts at each op and after every full group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_data_int <= '0;
        end else if (clr || valid_op || grp_done) begin
            sel_data_int <= '0;
        end else if (wr_en) begin
            sel_data_int <= sel_data_int + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_cnt <= '0;
        end else if (clr || valid_op) begin
            gen_cnt <= '0;
        end else if (en_gen_cnt) begin
            gen_cnt <= gen_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_bank_sel <= '0;
        end else if (end_inference) begin
            k_bank_sel <= '0;
        end else if (k_gen_id && valid_op) begin
            k_bank_sel <= k_bank_sel + 1'b1;
        end
    end

    // Only the selected K bank advances; each bank is its own ring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_K_BANKS; i++) k_bank[i] <= '0;
        end else if (end_inference) begin
            for (int i = 0; i < NUM_K_BANKS; i++) k_bank[i] <= '0;
        end else if (k_gen_id && wr_en) begin
            if (k_bank[k_bank_sel] == KV_LAST) k_bank[k_bank_sel] <= '0;
            else k_bank[k_bank_sel] <= k_bank[k_bank_sel] + 1'b1;
        end
    end

    assign k_ptr = k_bank[k_bank_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_ptr  <= '0;
            v_wrap <= 1'b0;
        end else if (end_inference) begin
            v_ptr  <= '0;
            v_wrap <= 1'b0;
        end else if (v_gen_id && valid_op) begin
            if (v_ptr == KV_LAST) begin
                v_ptr  <= '0;
                v_wrap <= 1'b1;
            end else begin
                v_ptr <= v_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_v <= '0;
        end else if (clr) begin
            offset_v <= '0;
        end else if (wr_en && v_gen_id) begin
            offset_v <= offset_v + LW'(offset_v_ext);
        end
    end

    assign offset_mm_si = (use_v_off == USE_V_WRAP);

    // Reaching the wrap value is observable for one op; the next op restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            use_v_off <= '0;
        end else if (offset_mm_si && valid_op) begin
            use_v_off <= '0;
        end else if (valid_op && use_v) begin
            use_v_off <= use_v_off + USE_V_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mode <= 1'b0;
        end else if (clr) begin
            err_mode <= 1'b0;
        end else if (v_gen_id && k_gen_id && (wr_en || valid_op)) begin
            err_mode <= 1'b1;
        end
    end

    assign timestep = DIM_TIMESTEP'(v_ptr >> TS_SHIFT);
    assign v_addr   = offset_v + LW'(timestep >> TS_SHIFT);

    always_comb begin
        logic_addr_c = gen_cnt;
        if (v_gen_id)      logic_addr_c = v_addr;
        else if (k_gen_id) logic_addr_c = k_ptr;
        else if (use_v)    logic_addr_c = gen_cnt + use_v_off;
    end

    assign phy_addr1_c = wr_baddr1 + MW'(logic_addr_c);
    assign phy_addr2_c = wr_baddr2 + MW'(logic_addr_c);

`ifdef KV_WR_ADDR_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logic_addr <= '0;
            phy_addr1  <= '0;
            phy_addr2  <= '0;
        end else begin
            logic_addr <= logic_addr_c;
            phy_addr1  <= phy_addr1_c;
            phy_addr2  <= phy_addr2_c;
        end
    end
`else
    assign logic_addr = logic_addr_c;
    assign phy_addr1  = phy_addr1_c;
    assign phy_addr2  = phy_addr2_c;
`endif

endmodule

// File: tb/tb_kv_wr_addr_gen.sv
// tb/tb_kv_wr_addr_gen.sv - directed self-checking bench for kv_wr_addr_gen (combinational-output build)
module tb_kv_wr_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, wr_en, valid_op, v_gen_id, k_gen_id, matmul_ss_id, use_v, end_inference;
    logic [5:0]  offset_v_ext;
    logic [13:0] wr_baddr1, wr_baddr2;
    logic [9:0]  logic_addr, k_ptr, v_ptr, gen_cnt;
    logic [13:0] phy_addr1, phy_addr2;
    logic [1:0]  k_bank_sel, sel_data_int;
    logic [7:0]  timestep;
    logic        offset_mm_si, v_wrap, err_mode;

    int vectors = 0;
    int fails   = 0;

    kv_wr_addr_gen dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .valid_op(valid_op),
        .v_gen_id(v_gen_id), .k_gen_id(k_gen_id), .matmul_ss_id(matmul_ss_id),
        .use_v(use_v), .end_inference(end_inference), .offset_v_ext(offset_v_ext),
        .wr_baddr1(wr_baddr1), .wr_baddr2(wr_baddr2), .logic_addr(logic_addr),
        .phy_addr1(phy_addr1), .phy_addr2(phy_addr2), .k_ptr(k_ptr),
        .k_bank_sel(k_bank_sel), .v_ptr(v_ptr), .timestep(timestep), .gen_cnt(gen_cnt),
        .sel_data_int(sel_data_int), .offset_mm_si(offset_mm_si), .v_wrap(v_wrap),
        .err_mode(err_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 0; wr_en = 0; valid_op = 0; v_gen_id = 0; k_gen_id = 0;
        matmul_ss_id = 0; use_v = 0; end_inference = 0; offset_v_ext = '0;
        wr_baddr1 = 14'h100; wr_baddr2 = 14'h200;
        cyc(2);
        chk("rst_gen_cnt", gen_cnt, 0);
        chk("rst_phy1", phy_addr1, 14'h100);
        chk("rst_phy2", phy_addr2, 14'h200);
        chk("rst_v_ptr", v_ptr, 0);
        chk("rst_err", err_mode, 0);
        rst_n = 1'b1;

        // general writes
        wr_en = 1; cyc(3); wr_en = 0; #1;
        chk("gen_cnt3", gen_cnt, 3);
        chk("phy1_103", phy_addr1, 14'h103);
        chk("phy2_203", phy_addr2, 14'h203);
        valid_op = 1; cyc(1); valid_op = 0; #1;
        chk("gen_cnt_vop", gen_cnt, 0);

        // matmul sub-sample groups
        matmul_ss_id = 1; wr_en = 1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk($sformatf("mm_sel_%0d", i), sel_data_int, i % 4);
        end
        chk("mm_gen_cnt", gen_cnt, 2);
        wr_en = 0; matmul_ss_id = 0;
        valid_op = 1; wr_en = 1; cyc(1); valid_op = 0; wr_en = 0; #1;
        chk("vop_wr_gen", gen_cnt, 0);
        chk("vop_wr_sel", sel_data_int, 0);

        // K banks
        k_gen_id = 1; wr_en = 1; cyc(5); wr_en = 0; #1;
        chk("k_bank0_5", k_ptr, 5);
        chk("k_laddr5", logic_addr, 5);
        valid_op = 1; cyc(1); valid_op = 0; #1;
        chk("k_sel1", k_bank_sel, 1);
        chk("k_bank1_0", k_ptr, 0);
        wr_en = 1; cyc(2); wr_en = 0; #1;
        chk("k_bank1_2", k_ptr, 2);
        valid_op = 1; cyc(2); #1;
        chk("k_sel3", k_bank_sel, 3);
        cyc(1); valid_op = 0; #1;
        chk("k_sel_wrap", k_bank_sel, 0);
        chk("k_back_bank0", k_ptr, 5);
        chk("k_phy2", phy_addr2, 14'h205);
        end_inference = 1; wr_en = 1; cyc(1); end_inference = 0; wr_en = 0; #1;
        chk("k_endinf_ptr", k_ptr, 0);
        wr_en = 1; cyc(799); #0;
        chk("k_799", k_ptr, 799);
        cyc(1); wr_en = 0; #1;
        chk("k_ring_wrap", k_ptr, 0);
        end_inference = 1; cyc(1); end_inference = 0; k_gen_id = 0; #1;

        // V ring
        v_gen_id = 1; valid_op = 1; cyc(799);
        chk("v_799", v_ptr, 799);
        chk("v_ts", timestep, 199);
        chk("v_laddr", logic_addr, 49);
        chk("v_nowrap", v_wrap, 0);
        cyc(2);
        chk("v_ptr_801", v_ptr, 1);
        chk("v_wrap1", v_wrap, 1);
        end_inference = 1; cyc(1); end_inference = 0; valid_op = 0; #1;
        chk("v_endinf_ptr", v_ptr, 0);
        chk("v_endinf_wrap", v_wrap, 0);
        offset_v_ext = 6'h3f; wr_en = 1; cyc(2); wr_en = 0; #1;
        chk("v_offset126", logic_addr, 126);
        clr = 1; cyc(1); clr = 0; v_gen_id = 0; #1;
        chk("v_offset_clr", logic_addr, 0);

        // use_v offsets
        use_v = 1;
        for (int i = 1; i <= 5; i++) begin
            valid_op = 1; cyc(1); valid_op = 0; #1;
            chk($sformatf("usev_laddr_%0d", i), logic_addr, (i == 5) ? 0 : 4 * i);
            chk($sformatf("usev_si_%0d", i), offset_mm_si, (i == 4) ? 1 : 0);
        end
        valid_op = 1; cyc(1); valid_op = 0; wr_en = 1; cyc(3); wr_en = 0; #1;
        chk("usev_gen_off", logic_addr, 7);
        use_v = 0; #1;
        chk("usev_off", logic_addr, 3);

        // mode conflict
        v_gen_id = 1; k_gen_id = 1; offset_v_ext = 6'd5; wr_en = 1; cyc(1); wr_en = 0; #1;
        chk("err_set", err_mode, 1);
        chk("err_vaddr", logic_addr, 5);
        cyc(2);
        chk("err_sticky", err_mode, 1);
        clr = 1; cyc(1); clr = 0; v_gen_id = 0; k_gen_id = 0; #1;
        chk("err_clr", err_mode, 0);
        chk("pre_rst_k", k_ptr, 1);
        wr_en = 1; cyc(2); wr_en = 0; #1;
        chk("pre_rst_gen", gen_cnt, 2);
        #2 rst_n = 1'b0; #1;
        chk("arst_gen", gen_cnt, 0);
        chk("arst_k", k_ptr, 0);
        chk("arst_phy1", phy_addr1, 14'h100);
        cyc(1); rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/kv_wr_addr_gen.md
Name: kv_wr_addr_gen

Overview:
- Write-address generator for the MMU write path. Successor to the fixed 4-bank generator.
- Produces logic and physical write addresses for general ops, K generation, V generation and matmul sub-sample writes.
- K bank count, matmul group size, use_v stride/group and K/V ring depth are all parametrised.
- Adds ring wrap of K/V pointers, sticky wrap and mode-conflict flags, and optional registered outputs.

Parameters:
- DIM_MAX_LOGIC_ADDRESS, 10, logic address / pointer width
- DIM_MAX_MEM, 14, physical address width
- DIM_TIMESTEP, 8, timestep width
- DIM_OFFSET, 6, offset_v_ext width
- NUM_K_BANKS, 4, number of K pointers (power of 2, >=2)
- MM_GROUP, 4, writes per matmul sub-sample group (power of 2, >=2)
- KV_DEPTH, 800, K/V ring depth; pointers wrap at KV_DEPTH-1
- TS_SHIFT, 2, right shift from v_ptr to timestep, and from timestep to the V address increment
- USE_V_STRIDE, 4, use_v logic-offset increment per valid_op
- USE_V_GROUPS, 4, use_v offset wraps at USE_V_STRIDE*USE_V_GROUPS

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  sync clear of gen_cnt, offset_v, mm counter and err_mode
- wr_en  in  1  write strobe
- valid_op  in  1  op boundary strobe
- v_gen_id  in  1  V generation stage
- k_gen_id  in  1  K generation stage
- matmul_ss_id  in  1  matmul sub-sample mode
- use_v  in  1  matmul using V
- end_inference  in  1  sync clear of K/V pointers, bank select and v_wrap
- offset_v_ext  in  DIM_OFFSET  V offset increment
- wr_baddr1, wr_baddr2  in  DIM_MAX_MEM  base addresses
- logic_addr  out  DIM_MAX_LOGIC_ADDRESS  selected logic address
- phy_addr1, phy_addr2  out  DIM_MAX_MEM  base + logic_addr
- k_ptr  out  DIM_MAX_LOGIC_ADDRESS  selected K pointer
- k_bank_sel  out  clog2(NUM_K_BANKS)  active K bank
- v_ptr  out  DIM_MAX_LOGIC_ADDRESS  V pointer
- timestep  out  DIM_TIMESTEP  v_ptr>>TS_SHIFT, truncated
- gen_cnt  out  DIM_MAX_LOGIC_ADDRESS  general counter
- sel_data_int  out  clog2(MM_GROUP)  matmul group index
- offset_mm_si  out  1  use_v offset at wrap value
- v_wrap  out  1  sticky: v_ptr wrapped
- err_mode  out  1  sticky: v_gen_id & k_gen_id both active

Behaviour:
- Reset: rst_n low asynchronously zeroes every register; all outputs derived from zero state (phy_addrX = wr_baddrX).
- Priority: rst_n > clear > load/increment at every register.
- mm counter (sel_data_int):
  - cleared by clr | valid_op | grp_done; else +1 on wr_en.
  - grp_done = wr_en & (cnt == MM_GROUP-1).
- gen_cnt:
  - cleared by clr | valid_op.
  - else +1 on en_gen_cnt = matmul_ss_id ? grp_done : wr_en.
- k_bank_sel:
  - +1 modulo NUM_K_BANKS on k_gen_id & valid_op.
  - cleared by end_inference.
- K pointers:
  - bank[k_bank_sel] +1 on k_gen_id & wr_en; value KV_DEPTH-1 wraps to 0.
  - all banks cleared by end_inference.
  - k_ptr = bank[k_bank_sel], combinational.
- v_ptr:
  - +1 on v_gen_id & valid_op; KV_DEPTH-1 wraps to 0 and sets v_wrap.
  - end_inference clears both v_ptr and v_wrap.
- offset_v:
  - += offset_v_ext (zero-extended, modulo 2^DIM_MAX_LOGIC_ADDRESS) on wr_en & v_gen_id.
  - cleared by clr.
  - v_addr = offset_v + (timestep>>TS_SHIFT).
- use_v offset:
  - += USE_V_STRIDE on valid_op & use_v.
  - offset_mm_si = (offset == USE_V_STRIDE*USE_V_GROUPS).
  - offset_mm_si & valid_op clears it; the clear wins over the add.
- logic_addr priority: v_gen_id ? v_addr : k_gen_id ? k_ptr : use_v ? gen_cnt+use_v_offset : gen_cnt.
- Physical addresses: phy_addrX = wr_baddrX + zero-extended logic_addr, modulo 2^DIM_MAX_MEM.
- err_mode:
  - set on v_gen_id & k_gen_id & (wr_en | valid_op); sticky until clr.
  - Addressing still follows the V-priority mux.
- Simultaneous events:
  - valid_op and wr_en in the same cycle: gen_cnt and mm counter clear, no increment.
  - end_inference together with k/v increment: clear wins.

Optional Feature:
- Macro: KV_WR_ADDR_REG_EN.
- Defined:
  - logic_addr, phy_addr1 and phy_addr2 are registered, adding 1 cycle of latency.
  - The registers reset to 0 on rst_n low.
- Undefined: these outputs are combinational, with 0 latency.
- All other outputs are combinational or direct register outputs in both builds.

Test Plan:
1. Reset, then 3 wr_en with all ids low and wr_baddr1=0x100 -> gen_cnt=3, phy_addr1=0x103; valid_op -> gen_cnt=0.
2. matmul_ss_id=1, 8 wr_en -> sel_data_int cycles 0,1,2,3,0,..; gen_cnt=2.
3. k_gen_id=1: 5 wr_en, valid_op, then 2 wr_en -> bank0=5, bank1=2, k_bank_sel=1. After NUM_K_BANKS valid_op total, k_bank_sel=0 and k_ptr=5.
4. v_gen_id=1, 801 valid_op with KV_DEPTH=800 -> v_ptr=1, v_wrap=1. end_inference -> v_ptr=0, v_wrap=0.
5. use_v=1, 5 valid_op -> offset 4,8,12,16 (offset_mm_si=1), then 0. logic_addr = gen_cnt + offset each cycle.
6. v_gen_id=k_gen_id=1 with wr_en -> err_mode=1, logic_addr = v_addr; clr -> err_mode=0. Assert rst_n low mid-sequence -> all zero asynchronously.
